// File: rtl/pe_lin_array.sv
// Weight-stationary 1-D systolic array: serial weight load, activations ripple PE0 -> PE(N-1),
// saturating MAC per PE, and a one-cycle snapshot of all accumulators after a drain.
module pe_lin_array #(
  parameter int N_PE     = 4,
  parameter int A_W      = 8,
  parameter int W_W      = 8,
  parameter int ACC_W    = 12,
  parameter int AUTO_CLR = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  w_load,
  input  logic                  w_valid,
  input  logic [W_W-1:0]        w_in,
  input  logic                  fire,
  input  logic [A_W-1:0]        in_a,
  output logic                  a_ready,
  input  logic                  flush,
  input  logic                  clear,
  output logic [N_PE*ACC_W-1:0] outs,
  output logic [N_PE-1:0]       ovf,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int P_W     = A_W + W_W;
  localparam int S_W     = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
  localparam int CNT_W   = $clog2(N_PE + 2);
  localparam int W_CNT_W = $clog2(N_PE);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [1:0]         state_reg;
  logic [W_CNT_W-1:0] w_cnt_reg;
  logic [CNT_W-1:0]   d_cnt_reg;
  logic [W_W-1:0]     w_reg     [N_PE];
  logic [A_W-1:0]     a_pipe    [N_PE];
  logic               v_pipe    [N_PE];
  logic [ACC_W-1:0]   acc_reg   [N_PE];
  logic               sticky_reg[N_PE];
  logic [N_PE*ACC_W-1:0] outs_reg;
  logic [N_PE-1:0]    ovf_reg;
  logic               out_valid_reg;

  logic accept, do_clear, snap, w_shift, auto_clr;

  always_comb begin
    a_ready  = (state_reg == RUN) | ((state_reg == IDLE) & ~w_load);
    accept   = fire & a_ready;
    do_clear = (state_reg == IDLE) & clear & ~w_load;
    snap     = (state_reg == DRAIN) & (d_cnt_reg == CNT_W'(N_PE));
    w_shift  = (state_reg == LOAD) & w_valid;
    auto_clr = snap & (AUTO_CLR != 0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      w_cnt_reg <= '0;
      d_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (w_load) begin
            state_reg <= LOAD;
            w_cnt_reg <= '0;
          end else if (fire) begin
            state_reg <= RUN;
          end else if (flush) begin
            state_reg <= DRAIN;
            d_cnt_reg <= '0;
          end
        end
        LOAD: begin
          if (w_valid) begin
            if (w_cnt_reg == W_CNT_W'(N_PE - 1)) state_reg <= IDLE;
            else                                 w_cnt_reg <= w_cnt_reg + 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            state_reg <= DRAIN;
            d_cnt_reg <= '0;
          end
        end
        default: begin
          if (snap) state_reg <= IDLE;
          else      d_cnt_reg <= d_cnt_reg + 1'b1;
        end
      endcase
    end
  end

  // Per-PE storage: weight shift chain, activation/valid pipe, saturating accumulator.
  generate
    for (genvar gi = 0; gi < N_PE; gi++) begin : g_pe
      logic [P_W-1:0] prod;
      logic [S_W-1:0] sum;
      logic           sat;

      always_comb begin
        prod = P_W'(a_pipe[gi]) * P_W'(w_reg[gi]);
        sum  = S_W'(acc_reg[gi]) + S_W'(prod);
        sat  = sum > S_W'(ACC_MAX);
      end

      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            w_reg[gi]  <= '0;
            a_pipe[gi] <= '0;
            v_pipe[gi] <= 1'b0;
          end else begin
            if (w_shift) w_reg[gi] <= w_in;
            a_pipe[gi] <= in_a;
            v_pipe[gi] <= accept;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            w_reg[gi]  <= '0;
            a_pipe[gi] <= '0;
            v_pipe[gi] <= 1'b0;
          end else begin
            if (w_shift) w_reg[gi] <= w_reg[gi-1];
            a_pipe[gi] <= a_pipe[gi-1];
            v_pipe[gi] <= v_pipe[gi-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          acc_reg[gi]    <= '0;
          sticky_reg[gi] <= 1'b0;
        end else if (do_clear || auto_clr) begin
          acc_reg[gi]    <= '0;
          sticky_reg[gi] <= 1'b0;
        end else if (v_pipe[gi]) begin
          acc_reg[gi] <= sat ? ACC_MAX : sum[ACC_W-1:0];
          if (sat) sticky_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Snapshot samples the pre-clear accumulators even when auto-clear fires on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outs_reg      <= '0;
      ovf_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= snap;
      if (snap) begin
        for (int i = 0; i < N_PE; i++) begin
          outs_reg[i*ACC_W +: ACC_W] <= acc_reg[i];
          ovf_reg[i]                 <= sticky_reg[i];
        end
      end
    end
  end

  assign outs      = outs_reg;
  assign ovf       = ovf_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);

endmodule
